// File: rtl/edge_frame_builder.sv
// Collects one frame of unique undirected station edges, replays it to the cost
// engine as a gap-free burst, then waits for the engine result or a timeout.
module edge_frame_builder #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_valid,
  output logic       up_ready,
  input  logic [3:0] up_src,
  input  logic [3:0] up_dst,
  input  logic       up_last,
  output logic       in_valid,
  output logic [3:0] source,
  output logic [3:0] destination,
  input  logic       out_valid,
  input  logic [3:0] cost,
  output logic       frame_done,
  output logic [3:0] frame_cost,
  output logic       frame_ovf,
  output logic       frame_timeout,
  output logic       empty_err
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [14:0] TO_LAST = 15'(TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

  state_t      state_q;
  logic [AW:0] count_q, rd_q;
  logic [255:0] adj_q;
  logic [7:0]  buf_q [DEPTH];
  logic        ovf_q;
  logic [14:0] tcnt_q;

  logic hs, self_loop, dup, full, keep;

  assign up_ready  = (state_q == FILL);
  assign hs        = up_valid && up_ready;
  assign self_loop = (up_src == up_dst);
  // Undirected: either orientation already in the map counts as a duplicate.
  assign dup       = adj_q[{up_src, up_dst}] | adj_q[{up_dst, up_src}];
  assign full      = (count_q == FULL);
  assign keep      = hs && !self_loop && !dup && !full;

  always_ff @(posedge clk) begin
    if (keep) buf_q[count_q[AW-1:0]] <= {up_src, up_dst};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      count_q       <= '0;
      rd_q          <= '0;
      adj_q         <= '0;
      ovf_q         <= 1'b0;
      tcnt_q        <= '0;
      in_valid      <= 1'b0;
      source        <= '0;
      destination   <= '0;
      frame_done    <= 1'b0;
      frame_cost    <= '0;
      frame_ovf     <= 1'b0;
      frame_timeout <= 1'b0;
      empty_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      empty_err  <= 1'b0;
      case (state_q)
        FILL: if (hs) begin
          if (!self_loop && !dup) begin
            if (full) ovf_q <= 1'b1;
            else begin
              adj_q[{up_src, up_dst}] <= 1'b1;
              count_q                 <= count_q + 1'b1;
            end
          end
          if (up_last) begin
            if (keep || count_q != '0) begin
              state_q <= SEND;
              rd_q    <= '0;
            end else begin
              empty_err <= 1'b1;
              adj_q     <= '0;
              ovf_q     <= 1'b0;
            end
          end
        end
        SEND: if (rd_q != count_q) begin
          in_valid               <= 1'b1;
          {source, destination}  <= buf_q[rd_q[AW-1:0]];
          rd_q                   <= rd_q + 1'b1;
        end else begin
          in_valid    <= 1'b0;
          source      <= '0;
          destination <= '0;
          tcnt_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: if (out_valid || tcnt_q == TO_LAST) begin
          // A result arriving on the expiry edge takes priority over the timeout.
          frame_done    <= 1'b1;
          frame_cost    <= out_valid ? cost : 4'd0;
          frame_ovf     <= ovf_q;
          frame_timeout <= !out_valid;
          count_q       <= '0;
          adj_q         <= '0;
          ovf_q         <= 1'b0;
          state_q       <= FILL;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_frame_builder.sv
// Scoreboard bench for edge_frame_builder: a reference filter model queues the
// expected burst beats and frame results, a monitor pops and compares them.
module tb_edge_frame_builder;
  localparam int DEPTH = 32;
  localparam int TO    = 100;

  logic       clk, rst;
  logic       up_valid, up_ready, up_last;
  logic [3:0] up_src, up_dst;
  logic       in_valid;
  logic [3:0] source, destination;
  logic       out_valid, ov_eng, ov_stray;
  logic [3:0] cost, cost_eng;
  logic       frame_done, frame_ovf, frame_timeout, empty_err;
  logic [3:0] frame_cost;

  assign out_valid = ov_eng | ov_stray;
  assign cost      = cost_eng;

  edge_frame_builder #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_src(up_src), .up_dst(up_dst), .up_last(up_last),
    .in_valid(in_valid), .source(source), .destination(destination),
    .out_valid(out_valid), .cost(cost),
    .frame_done(frame_done), .frame_cost(frame_cost), .frame_ovf(frame_ovf),
    .frame_timeout(frame_timeout), .empty_err(empty_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cost;
    logic        ovf;
    logic        tmo;
    logic [31:0] lat;
  } fexp_t;

  int n_tests = 0, n_fail = 0;
  logic [7:0] sb[$];
  int         lq[$];
  fexp_t      fq[$];
  int         exp_empty = 0;

  // reference model state for the frame being filled
  bit         m_adj[256];
  int         m_cnt = 0;
  bit         m_ovf = 0;
  logic [7:0] m_beats[$];

  // engine model controls
  bit         eng_on = 1;
  int         eng_delay = 4;
  logic [3:0] eng_cost = 4'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic close_frame();
    fexp_t f;
    if (m_cnt == 0) exp_empty++;
    else begin
      foreach (m_beats[i]) sb.push_back(m_beats[i]);
      lq.push_back(m_cnt);
      if (eng_on && eng_delay <= TO) begin
        f.cost = eng_cost; f.tmo = 1'b0; f.lat = 32'(eng_delay);
      end else begin
        f.cost = 4'd0;     f.tmo = 1'b1; f.lat = 32'(TO);
      end
      f.ovf = m_ovf;
      fq.push_back(f);
    end
    foreach (m_adj[i]) m_adj[i] = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_beats.delete();
  endtask

  task automatic put_edge(input logic [3:0] s, input logic [3:0] d, input bit last);
    int t = 0;
    @(negedge clk);
    while (!up_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("ready_wait", 32'(up_ready), 32'd1);
    up_valid = 1'b1; up_src = s; up_dst = d; up_last = last;
    if (s != d && !m_adj[{s, d}] && !m_adj[{d, s}]) begin
      if (m_cnt == DEPTH) m_ovf = 1'b1;
      else begin
        m_adj[{s, d}] = 1'b1;
        m_cnt++;
        m_beats.push_back({s, d});
      end
    end
    if (last) close_frame();
    @(posedge clk); #1;
    up_valid = 1'b0; up_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || lq.size() != 0 || fq.size() != 0 || exp_empty != 0) && t < 1000) begin
      @(negedge clk); t++;
    end
    if (t >= 1000) chk("idle_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  // cost engine: answers eng_delay edges after the burst's falling edge
  initial begin
    bit e_prev = 1'b0;
    ov_eng = 1'b0; cost_eng = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst && e_prev && !in_valid && eng_on) begin
        repeat (eng_delay - 1) @(negedge clk);
        ov_eng = 1'b1; cost_eng = eng_cost;
        @(negedge clk);
        ov_eng = 1'b0; cost_eng = 4'd0;
      end
      e_prev = rst ? 1'b0 : in_valid;
    end
  end

  // monitor
  int run_len = 0, wcnt = 0;
  bit prev_iv = 1'b0;
  always @(negedge clk) begin
    fexp_t f;
    if (rst) begin
      run_len = 0; prev_iv = 1'b0; wcnt = 0;
    end else begin
      if (in_valid) begin
        run_len++;
        if (sb.size() == 0) chk("beat_unexp", 32'({source, destination}), 32'hFFFF);
        else chk("beat", 32'({source, destination}), 32'(sb.pop_front()));
      end else if (prev_iv) begin
        if (lq.size() == 0) chk("burst_unexp", 32'(run_len), 32'd0);
        else chk("burst_len", 32'(run_len), 32'(lq.pop_front()));
        run_len = 0; wcnt = 0;
      end else wcnt++;
      if (frame_done) begin
        if (fq.size() == 0) chk("done_unexp", 32'd1, 32'd0);
        else begin
          f = fq.pop_front();
          chk("frame_cost", 32'(frame_cost), 32'(f.cost));
          chk("frame_ovf", 32'(frame_ovf), 32'(f.ovf));
          chk("frame_timeout", 32'(frame_timeout), 32'(f.tmo));
          chk("done_latency", 32'(wcnt), f.lat);
          chk("ready_at_done", 32'(up_ready), 32'd1);
        end
      end
      if (empty_err) begin
        chk("empty_err", 32'd1, 32'(exp_empty > 0));
        if (exp_empty > 0) exp_empty--;
      end
      prev_iv = in_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; up_valid = 1'b0; up_last = 1'b0; up_src = '0; up_dst = '0; ov_stray = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_src_dst", 32'({source, destination}), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_flags", 32'({frame_cost, frame_ovf, frame_timeout, empty_err}), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("rst_up_ready", 32'(up_ready), 32'd1);

    // basic frame
    eng_on = 1; eng_delay = 4; eng_cost = 4'd3;
    put_edge(4'd0, 4'd1, 0); put_edge(4'd1, 4'd2, 0); put_edge(4'd2, 4'd15, 1);
    wait_idle();

    // filtering, then map-cleared check
    eng_cost = 4'd7;
    put_edge(4'd3, 4'd4, 0); put_edge(4'd4, 4'd3, 0); put_edge(4'd5, 4'd5, 0);
    put_edge(4'd3, 4'd4, 0); put_edge(4'd4, 4'd6, 1);
    wait_idle();
    eng_cost = 4'd2;
    put_edge(4'd3, 4'd4, 1);
    wait_idle();

    // overflow: 34 distinct edges
    eng_cost = 4'd1;
    n = 0;
    for (int s = 0; s < 16 && n < 34; s++)
      for (int d = s + 1; d < 16 && n < 34; d++) begin
        n++;
        put_edge(4'(s), 4'(d), n == 34);
      end
    wait_idle();

    // timeout with silent engine
    eng_on = 0;
    put_edge(4'd1, 4'd3, 1);
    wait_idle();

    // result on the expiry edge wins
    eng_on = 1; eng_delay = TO; eng_cost = 4'd9;
    put_edge(4'd2, 4'd3, 1);
    wait_idle();

    // stray engine strobe while idle, then an empty frame
    eng_delay = 4; eng_cost = 4'd5;
    @(negedge clk); ov_stray = 1'b1;
    @(negedge clk); ov_stray = 1'b0;
    put_edge(4'd7, 4'd7, 1);
    wait_idle();
    chk("empty_ready", 32'(up_ready), 32'd1);

    // reset on the 2nd burst cycle of a 5-edge frame
    eng_on = 0;
    for (int d = 11; d < 16; d++) put_edge(4'd10, 4'(d), d == 15);
    @(posedge clk); @(posedge clk); #1;
    chk("iv_before_rst", 32'(in_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_valid", 32'(in_valid), 32'd0);
    chk("midrst_src_dst", 32'({source, destination}), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    sb.delete(); lq.delete(); fq.delete();
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
    #1 chk("midrst_up_ready", 32'(up_ready), 32'd1);
    eng_on = 1; eng_delay = 4; eng_cost = 4'd5;
    put_edge(4'd8, 4'd9, 1);
    wait_idle();

    chk("sb_drained", 32'(sb.size() + lq.size() + fq.size()), 32'd0);
    chk("empty_drained", 32'(exp_empty), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_frame_builder.md
Name: edge_frame_builder

Overview:
- Upstream stage of the station shortest-path cost engine.
- Accepts undirected station edges one at a time over a valid/ready interface. Drops self-loops and duplicate edges, and buffers each frame until it is complete.
- Replays the frame to the cost engine as one gap-free in_valid burst (source/destination pairs), then waits for the engine's one-cycle out_valid/cost result.
- Reports the result upstream and holds off the next frame while the engine is busy.

Parameters:
- DEPTH, 32, maximum stored edges per frame (power of 2, ≤ 64).
- TIMEOUT, 30000, cycles allowed in WAIT for out_valid before the frame is abandoned.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- up_valid  in  1  upstream edge valid.
- up_ready  out  1  high only in FILL.
- up_src  in  4  edge endpoint A (station 0..15).
- up_dst  in  4  edge endpoint B (station 0..15).
- up_last  in  1  marks the final edge of the frame.
- in_valid  out  1  to cost engine; burst of stored edges.
- source  out  4  to cost engine; edge endpoint A.
- destination  out  4  to cost engine; edge endpoint B.
- out_valid  in  1  from cost engine; result strobe.
- cost  in  4  from cost engine; result value.
- frame_done  out  1  one-cycle pulse; a frame has finished.
- frame_cost  out  4  captured cost, valid with frame_done, held until the next frame_done.
- frame_ovf  out  1  valid with frame_done; more than DEPTH unique edges were offered.
- frame_timeout  out  1  valid with frame_done; engine gave no result.
- empty_err  out  1  one-cycle pulse; frame closed with zero stored edges.

Behaviour:
- Reset (async, immediate, from any state):
  - State = FILL.
  - in_valid=0, source=0, destination=0.
  - frame_done=0, frame_cost=0, frame_ovf=0, frame_timeout=0, empty_err=0.
  - Edge count=0, 256-bit adjacency map cleared, timeout counter=0.
  - up_ready=1 once rst deasserts.
- All outputs are registered except up_ready, which is decoded from state.
- FILL:
  - Handshake = up_valid && up_ready.
  - Per accepted edge (s,d):
    - s==d → dropped.
    - adj[s][d] or adj[d][s] set → dropped as duplicate.
    - count==DEPTH → dropped, sticky ovf flag set.
    - Otherwise: written to buffer[count], adj[s][d] set, count++.
  - Drop decisions use the map state before this edge's own write.
  - up_last handshake closes the frame whether or not that edge was kept.
    - count>0 after the close → SEND.
    - count==0 → empty_err pulses on the next edge, map/ovf cleared, stay FILL.
- SEND:
  - Let the up_last handshake occur at edge E.
  - in_valid rises at edge E+1 and stays high exactly N=count cycles, with no gaps.
  - Buffered edges are presented in arrival order, one per cycle.
  - At edge E+1+N: in_valid=0, source=0, destination=0, state → WAIT, timeout counter=0.
- WAIT:
  - Timeout counter increments each cycle.
  - out_valid sampled high at edge W:
    - frame_cost=cost, frame_ovf=sticky ovf, frame_timeout=0.
    - frame_done=1 for the cycle starting at W.
    - Clear count, map and ovf; → FILL, so up_ready is high from W.
  - Counter reaches TIMEOUT-1 with no out_valid:
    - Same completion, but frame_cost=0 and frame_timeout=1.
  - out_valid on the same edge as timeout expiry: the result wins and frame_timeout=0.
- out_valid or cost seen outside WAIT: ignored, no flag.
- up_* inputs are ignored outside FILL because up_ready=0 there.
- Widths: count is log2(DEPTH)+1 bits; timeout counter is 15 bits.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → in_valid, source, destination, frame_done all 0 immediately; after release up_ready=1.
- Basic frame: edges (0,1),(1,2),(2,15,last), engine model returns cost=3 four cycles after the burst → in_valid high exactly 3 consecutive cycles carrying (0,1),(1,2),(2,15); frame_done single pulse with frame_cost=3, frame_ovf=0, frame_timeout=0; next frame accepted in the following cycle.
- Filtering: (3,4),(4,3),(5,5),(3,4),(4,6,last) → burst of 2 cycles (3,4),(4,6) only; then a new frame containing (3,4) is accepted again, showing the map was cleared.
- Overflow: 34 distinct edges with DEPTH=32 → burst of 32 cycles containing the first 32 edges; frame_done with frame_ovf=1.
- Timeout/race: TIMEOUT=100 with no out_valid → frame_done at cycle 100 of WAIT with frame_timeout=1, frame_cost=0. Repeat with out_valid=1, cost=9 on the expiry cycle → frame_cost=9, frame_timeout=0.
- Empty frame and reset mid-burst:
  - Frame of only (7,7,last) → empty_err pulse, no in_valid, up_ready stays 1.
  - rst asserted on the 2nd burst cycle of a 5-edge frame → in_valid drops at once; after release, a fresh 1-edge frame completes normally.
